// File: rtl/rv32i_ldst_ctrl.sv
// Load/store controller bridging the RV32I ALU to an Avalon-MM master port.
// One access at a time; the pipeline is frozen via stall until the access completes or times out.
module rv32i_ldst_ctrl #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] addr,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_data,
  output logic        stall,
  output logic        clr_load_op,
  output logic [31:0] ld_data,
  output logic        bus_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] cnt;
  logic        is_load;
  logic        timeout;

  assign timeout = (cnt == TMO);

  // Freeze the pipeline as soon as a request appears, and release it in DONE.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:         stall = load | store;
      RD, RDW, WR:  stall = 1'b1;
      DONE:         stall = 1'b0;
      default:      stall = 1'b0;
    endcase
  end

  // Access sequencer; every output except stall is a register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= 16'd0;
      is_load        <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= 32'd0;
      avm_byteenable <= 4'd0;
      avm_writedata  <= 32'd0;
      ld_data        <= 32'd0;
      clr_load_op    <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_load_op <= 1'b0;
          bus_err     <= 1'b0;
          cnt         <= 16'd0;
          if (load) begin
            avm_address    <= addr;
            avm_byteenable <= 4'hF;
            avm_read       <= 1'b1;
            is_load        <= 1'b1;
            state          <= RD;
          end else if (store) begin
            avm_address    <= addr;
            avm_byteenable <= st_be;
            avm_writedata  <= st_data;
            avm_write      <= 1'b1;
            is_load        <= 1'b0;
            state          <= WR;
          end else begin
            state <= IDLE;
          end
        end
        RD, RDW, WR: begin
          if (timeout) begin
            avm_read    <= 1'b0;
            avm_write   <= 1'b0;
            ld_data     <= 32'd0;
            bus_err     <= 1'b1;
            clr_load_op <= is_load;
            state       <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
            if (state == WR) begin
              if (!avm_waitrequest) begin
                avm_write <= 1'b0;
                state     <= DONE;
              end else begin
                state <= WR;
              end
            end else if (state == RD && avm_waitrequest) begin
              state <= RD;
            end else begin
              // Read accepted (or already waiting): readdatavalid may arrive in the accept cycle.
              avm_read <= 1'b0;
              if (avm_readdatavalid) begin
                ld_data     <= avm_readdata;
                clr_load_op <= 1'b1;
                state       <= DONE;
              end else begin
                state <= RDW;
              end
            end
          end
        end
        DONE: begin
          clr_load_op <= 1'b0;
          bus_err     <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_ldst_ctrl.sv
// Directed self-checking bench for rv32i_ldst_ctrl (instantiated with TIMEOUT=8).
// Each cycle: registered outputs are checked 1 time unit after the edge, inputs driven, stall checked 1 unit later.
module tb_rv32i_ldst_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load, store;
  logic [31:0] addr;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        stall, clr_load_op, bus_err;
  logic [31:0] ld_data;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid, avm_waitrequest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_ldst_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .store(store), .addr(addr),
    .st_be(st_be), .st_data(st_data), .stall(stall), .clr_load_op(clr_load_op),
    .ld_data(ld_data), .bus_err(bus_err), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load = 1'b0; store = 1'b0; addr = 32'd0; st_be = 4'd0; st_data = 32'd0;
    avm_readdata = 32'd0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    #3;
    checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b exp 0", avm_read); end
    checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b exp 0", avm_write); end
    checks++; if (avm_address !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h exp 0", avm_address); end
    checks++; if (avm_byteenable !== 4'd0) begin errors++; $display("FAIL reset_be: got %h exp 0", avm_byteenable); end
    checks++; if (avm_writedata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", avm_writedata); end
    checks++; if (ld_data !== 32'd0) begin errors++; $display("FAIL reset_ld_data: got %h exp 0", ld_data); end
    checks++; if ({clr_load_op, bus_err, stall} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {clr_load_op, bus_err, stall}); end
    #20;
    reset_n = 1'b1;
  endtask

  // Cycle 0 request, cycle 1 strobe, cycle 2 data, cycle 3 DONE; optional simultaneous store must be dropped.
  task automatic zero_wait_read(input logic [31:0] a, input logic [31:0] d, input logic with_store);
    tick();
    load = 1'b1; store = with_store; addr = a; st_be = 4'hA; st_data = 32'h5555AAAA;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL zw_stall_c0: got %b exp 1", stall); end
    checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL zw_read_c0: got %b exp 0", avm_read); end
    tick();
    checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL zw_read_c1: got %b exp 1", avm_read); end
    checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL zw_write_c1: got %b exp 0", avm_write); end
    checks++; if (avm_address !== a) begin errors++; $display("FAIL zw_addr_c1: got %h exp %h", avm_address, a); end
    checks++; if (avm_byteenable !== 4'hF) begin errors++; $display("FAIL zw_be_c1: got %h exp f", avm_byteenable); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL zw_stall_c1: got %b exp 1", stall); end
    tick();
    checks++; if ({avm_read, avm_write} !== 2'b00) begin errors++; $display("FAIL zw_strobes_c2: got %b exp 00", {avm_read, avm_write}); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL zw_stall_c2: got %b exp 1", stall); end
    avm_readdata = d; avm_readdatavalid = 1'b1;
    tick();
    checks++; if (ld_data !== d) begin errors++; $display("FAIL zw_ld_data_c3: got %h exp %h", ld_data, d); end
    checks++; if (clr_load_op !== 1'b1) begin errors++; $display("FAIL zw_clr_c3: got %b exp 1", clr_load_op); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zw_stall_c3: got %b exp 0", stall); end
    checks++; if ({bus_err, avm_write} !== 2'b00) begin errors++; $display("FAIL zw_err_write_c3: got %b exp 00", {bus_err, avm_write}); end
    load = 1'b0; store = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
    tick();
    checks++; if ({clr_load_op, stall, avm_write} !== 3'b000) begin errors++; $display("FAIL zw_c4: got %b exp 000", {clr_load_op, stall, avm_write}); end
    checks++; if (ld_data !== d) begin errors++; $display("FAIL zw_ld_hold_c4: got %h exp %h", ld_data, d); end
  endtask

  task automatic test_zero_wait_read();
    zero_wait_read(32'h00000100, 32'hCAFEF00D, 1'b0);
  endtask

  task automatic test_waited_read();
    tick();
    load = 1'b1; addr = 32'h00000300; avm_waitrequest = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      addr = 32'hFFFF0000;
      checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL wr_read_hold c%0d: got %b exp 1", c, avm_read); end
      checks++; if (avm_address !== 32'h00000300) begin errors++; $display("FAIL wr_addr_hold c%0d: got %h exp 300", c, avm_address); end
    end
    tick();
    avm_waitrequest = 1'b0;
    checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL wr_read_c4: got %b exp 1", avm_read); end
    for (int c = 5; c <= 6; c++) begin
      tick();
      if (c == 6) begin avm_readdata = 32'h12345678; avm_readdatavalid = 1'b1; end
      #1;
      checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL wr_no_restrobe c%0d: got %b exp 0", c, avm_read); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wr_stall c%0d: got %b exp 1", c, stall); end
    end
    tick();
    checks++; if (ld_data !== 32'h12345678) begin errors++; $display("FAIL wr_ld_data: got %h exp 12345678", ld_data); end
    checks++; if ({clr_load_op, stall} !== 2'b10) begin errors++; $display("FAIL wr_done: got %b exp 10", {clr_load_op, stall}); end
    load = 1'b0; avm_readdatavalid = 1'b0;
  endtask

  task automatic test_store();
    tick();
    store = 1'b1; addr = 32'h00000204; st_be = 4'b0100; st_data = 32'h00AB0000; avm_waitrequest = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      if (c == 1) begin avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADDEAD; end
      else begin avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0; end
      checks++; if (avm_write !== 1'b1) begin errors++; $display("FAIL st_write c%0d: got %b exp 1", c, avm_write); end
      checks++; if (avm_address !== 32'h00000204) begin errors++; $display("FAIL st_addr c%0d: got %h exp 204", c, avm_address); end
      checks++; if (avm_byteenable !== 4'b0100) begin errors++; $display("FAIL st_be c%0d: got %b exp 0100", c, avm_byteenable); end
      checks++; if (avm_writedata !== 32'h00AB0000) begin errors++; $display("FAIL st_wdata c%0d: got %h exp 00ab0000", c, avm_writedata); end
      checks++; if ({avm_read, clr_load_op} !== 2'b00) begin errors++; $display("FAIL st_read_clr c%0d: got %b exp 00", c, {avm_read, clr_load_op}); end
    end
    tick();
    checks++; if ({avm_write, clr_load_op, stall, bus_err} !== 4'b0000) begin errors++; $display("FAIL st_done: got %b exp 0000", {avm_write, clr_load_op, stall, bus_err}); end
    checks++; if (ld_data !== 32'h12345678) begin errors++; $display("FAIL st_ld_hold: got %h exp 12345678", ld_data); end
    store = 1'b0;
  endtask

  task automatic test_load_store_collision();
    zero_wait_read(32'h00000500, 32'hA5A5_0F0F, 1'b1);
  endtask

  // TIMEOUT=8: nine cycles in the access states, bus_err in the tenth cycle after the request.
  task automatic test_timeout();
    tick();
    load = 1'b1; addr = 32'h00000400; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++; if ({bus_err, stall} !== 2'b01) begin errors++; $display("FAIL to_wait c%0d: got %b exp 01", c, {bus_err, stall}); end
    end
    tick();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err: got %b exp 1", bus_err); end
    checks++; if (ld_data !== 32'd0) begin errors++; $display("FAIL to_ld_data: got %h exp 0", ld_data); end
    checks++; if ({avm_read, stall} !== 2'b00) begin errors++; $display("FAIL to_read_stall: got %b exp 00", {avm_read, stall}); end
    load = 1'b0;
    tick();
    checks++; if ({bus_err, stall, avm_read} !== 3'b000) begin errors++; $display("FAIL to_idle: got %b exp 000", {bus_err, stall, avm_read}); end
  endtask

  task automatic test_reset_mid_access();
    tick();
    load = 1'b1; addr = 32'h00000600; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    tick();
    tick();
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({avm_read, avm_write, bus_err, clr_load_op} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b exp 0000", {avm_read, avm_write, bus_err, clr_load_op}); end
    checks++; if (avm_address !== 32'd0) begin errors++; $display("FAIL rst_mid_addr: got %h exp 0", avm_address); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_stall_load: got %b exp 1", stall); end
    load = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall_idle: got %b exp 0", stall); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_mid_bus_err: got %b exp 0", bus_err); end
    zero_wait_read(32'h00000700, 32'h0BADBEEF, 1'b0);
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_waited_read();
    test_store();
    test_load_store_collision();
    test_timeout();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
